// File: rtl/hpu_soft_reset_pkg.sv
// Shared types and constants for the HPU soft-reset request controller.
// Status bit positions are shared with the register map.
package hpu_soft_reset_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GUARD
    } state_t;

    localparam int ST_DONE = 0;
    localparam int ST_TMO  = 1;
    localparam int ST_SPUR = 2;
    localparam int ST_W    = 3;

    // Timer width covering the larger of the two reload values
    function automatic int tmr_w(input int a, input int b);
        return $clog2(a > b ? a : b);
    endfunction

endpackage

// File: rtl/hpu_soft_reset_req.sv
// Upstream soft-reset handshake controller: request -> hpu_reset level,
// completion timeout, guard gap, sticky status and completed-reset counter.
module hpu_soft_reset_req
    import hpu_soft_reset_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int GUARD_CYCLES   = 8,
    parameter int CNT_W          = 16
) (
    input  logic             cfg_clk,
    input  logic             cfg_a_rst_n,
    input  logic             req_vld,
    output logic             req_rdy,
    input  logic             clr_status,
    output logic             hpu_reset,
    input  logic             hpu_reset_done,
    output logic             busy,
    output logic             done_sticky,
    output logic             timeout_err,
    output logic             spurious_err,
    output logic             irq,
    output logic [CNT_W-1:0] reset_cnt
);

    localparam int TMR_W = tmr_w(TIMEOUT_CYCLES, GUARD_CYCLES);
    localparam logic [TMR_W-1:0] TMO_LD = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] GRD_LD = TMR_W'(GUARD_CYCLES - 1);

    state_t            state_q;
    state_t            state_d;
    logic [TMR_W-1:0]  tmr_q;
    logic [TMR_W-1:0]  tmr_d;
    logic [ST_W-1:0]   status_q;
    logic [ST_W-1:0]   st_set;
    logic [CNT_W-1:0]  cnt_q;
    logic              cnt_inc;
    logic              irq_d;
    logic              irq_q;
    logic              hpu_reset_q;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        st_set  = '0;
        cnt_inc = 1'b0;
        irq_d   = 1'b0;
        req_rdy = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_rdy = 1'b1;
                if (req_vld) begin
                    state_d = REQ;
                    tmr_d   = TMO_LD;
                end
            end
            REQ: begin
                // A done pulse on the expiry cycle still counts as completion
                if (hpu_reset_done) begin
                    state_d         = GUARD;
                    tmr_d           = GRD_LD;
                    st_set[ST_DONE] = 1'b1;
                    cnt_inc         = 1'b1;
                    irq_d           = 1'b1;
                end else if (tmr_q == '0) begin
                    state_d        = GUARD;
                    tmr_d          = GRD_LD;
                    st_set[ST_TMO] = 1'b1;
                    irq_d          = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            GUARD: begin
                if (tmr_q == '0) begin
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tmr_d   = '0;
            end
        endcase
        if (hpu_reset_done && state_q != REQ) begin
            st_set[ST_SPUR] = 1'b1;
        end
    end

    always_ff @(posedge cfg_clk or negedge cfg_a_rst_n) begin
        if (!cfg_a_rst_n) begin
            state_q     <= IDLE;
            tmr_q       <= '0;
            status_q    <= '0;
            cnt_q       <= '0;
            irq_q       <= 1'b0;
            hpu_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            irq_q       <= irq_d;
            hpu_reset_q <= (state_d == REQ);
            status_q    <= st_set | (status_q & ~{ST_W{clr_status}});
            if (cnt_inc && cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign hpu_reset    = hpu_reset_q;
    assign busy         = (state_q != IDLE);
    assign done_sticky  = status_q[ST_DONE];
    assign timeout_err  = status_q[ST_TMO];
    assign spurious_err = status_q[ST_SPUR];
    assign irq          = irq_q;
    assign reset_cnt    = cnt_q;

endmodule
